// File: rtl/capture_dump_sender.sv
// capture_dump_sender: command decoder that arms a sampling run and streams capture memory to a UART transmitter.
module capture_dump_sender #(
    parameter int          ADDR_W     = 16,
    parameter int          DATA_W     = 8,
    parameter int          AUTO_DUMP  = 1,
    parameter logic [7:0]  CMD_SAMPLE = 8'h53,
    parameter logic [7:0]  CMD_DUMP   = 8'h44,
    parameter logic [7:0]  CMD_ABORT  = 8'h58
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [7:0]        iRx_data,
    input  logic              iRx_done,
    output logic [7:0]        oTx_data,
    output logic              oTx_start,
    input  logic              iTx_busy,
    output logic              oSample_start,
    input  logic              iSampling_finished,
    output logic [ADDR_W-1:0] oAddress,
    input  logic [DATA_W-1:0] iData,
    output logic              oBusy
);
    localparam int NB = DATA_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    typedef enum logic [3:0] {IDLE, ARM, WAIT_SAMPLE, READ, LOAD, SEND, GAP, WAIT_TX, NEXT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              sample_start_q, sample_start_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;
    logic              rx_abort;

    assign rx_abort = iRx_done && iRx_data == CMD_ABORT;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        abort_d   = abort_q || (rx_abort && state_q inside {READ, LOAD, SEND, GAP, WAIT_TX, NEXT});
        case (state_q)
            IDLE: begin
                if (iRx_done && iRx_data == CMD_SAMPLE) state_d = ARM;
                else if (iRx_done && iRx_data == CMD_DUMP) state_d = READ;
            end
            ARM: state_d = WAIT_SAMPLE;
            WAIT_SAMPLE: begin
                if (rx_abort) state_d = IDLE;
                else if (iSampling_finished) state_d = AUTO_DUMP != 0 ? READ : IDLE;
            end
            READ: state_d = LOAD;
            LOAD: begin
                shreg_d   = iData;
                idx_d     = '0;
                tx_data_d = iData[DATA_W-1 -: 8];
                state_d   = SEND;
            end
            SEND: state_d = GAP;
            GAP:  state_d = WAIT_TX;
            WAIT_TX: begin
                if (!iTx_busy) begin
                    if (abort_q || rx_abort) state_d = IDLE;
                    else if (int'(idx_q) < NB - 1) begin
                        idx_d     = idx_q + 1'b1;
                        shreg_d   = shreg_q << 8;
                        tx_data_d = shreg_d[DATA_W-1 -: 8];
                        state_d   = SEND;
                    end else state_d = NEXT;
                end
            end
            NEXT: begin
                state_d = &addr_q ? IDLE : READ;
                addr_d  = addr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // every way back to IDLE parks the address at 0 and drops any pending abort
        if (state_d == IDLE) begin
            addr_d  = '0;
            abort_d = 1'b0;
        end
        tx_start_d     = state_d == SEND;
        sample_start_d = state_d == ARM;
        busy_d         = state_d != IDLE;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            shreg_q        <= '0;
            idx_q          <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            sample_start_q <= 1'b0;
            busy_q         <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            shreg_q        <= shreg_d;
            idx_q          <= idx_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            sample_start_q <= sample_start_d;
            busy_q         <= busy_d;
            abort_q        <= abort_d;
        end
    end

    assign oTx_data      = tx_data_q;
    assign oTx_start     = tx_start_q;
    assign oSample_start = sample_start_q;
    assign oAddress      = addr_q;
    assign oBusy         = busy_q;
endmodule

// File: tb/tb_capture_dump_sender.sv
// tb_capture_dump_sender: scoreboard bench; instance a auto-dumps 16-bit words, instance b waits for the dump command.
module tb_capture_dump_sender;
    localparam int AW = 4, DW = 16, BA = 3, BW = 8;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    logic [7:0]    a_rx_data = 0, a_tx_data;
    logic          a_rx_done = 0, a_tx_start, a_tx_busy, a_sample_start, a_fin = 0, a_busy;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data = 0;
    logic [DW-1:0] a_mem [1 << AW];
    logic [7:0]    qa [$];
    int            a_cnt = 0, a_tbyte = 3, a_tlast = 3, a_samples = 0;

    logic [7:0]    b_rx_data = 0, b_tx_data;
    logic          b_rx_done = 0, b_tx_start, b_tx_busy, b_sample_start, b_fin = 0, b_busy;
    logic [BA-1:0] b_addr;
    logic [BW-1:0] b_data = 0;
    logic [BW-1:0] b_mem [1 << BA];
    logic [7:0]    qb [$];
    int            b_cnt = 0, b_samples = 0;

    capture_dump_sender #(.ADDR_W(AW), .DATA_W(DW), .AUTO_DUMP(1)) dut_a (
        .iClk(clk), .iRst_n(rst_n), .iRx_data(a_rx_data), .iRx_done(a_rx_done),
        .oTx_data(a_tx_data), .oTx_start(a_tx_start), .iTx_busy(a_tx_busy),
        .oSample_start(a_sample_start), .iSampling_finished(a_fin),
        .oAddress(a_addr), .iData(a_data), .oBusy(a_busy));

    capture_dump_sender #(.ADDR_W(BA), .DATA_W(BW), .AUTO_DUMP(0)) dut_b (
        .iClk(clk), .iRst_n(rst_n), .iRx_data(b_rx_data), .iRx_done(b_rx_done),
        .oTx_data(b_tx_data), .oTx_start(b_tx_start), .iTx_busy(b_tx_busy),
        .oSample_start(b_sample_start), .iSampling_finished(b_fin),
        .oAddress(b_addr), .iData(b_data), .oBusy(b_busy));

    // synchronous-read memories and transmitters that go busy the cycle after a start strobe
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
        if (a_tx_start) a_cnt <= (a_addr == {AW{1'b1}}) ? a_tlast : a_tbyte;
        else if (a_cnt > 0) a_cnt <= a_cnt - 1;
        if (b_tx_start) b_cnt <= 2;
        else if (b_cnt > 0) b_cnt <= b_cnt - 1;
    end
    assign a_tx_busy = a_cnt != 0;
    assign b_tx_busy = b_cnt != 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_sample_start) a_samples++;
        if (b_sample_start) b_samples++;
        if (a_tx_start) begin
            chk("a_handshake", 32'(a_tx_busy), 0);
            if (qa.size() == 0) chk("a_tx_extra", 32'(qa.size()), 1);
            else chk("a_tx_byte", 32'(a_tx_data), 32'(qa.pop_front()));
        end
        if (b_tx_start) begin
            chk("b_handshake", 32'(b_tx_busy), 0);
            if (qb.size() == 0) chk("b_tx_extra", 32'(qb.size()), 1);
            else chk("b_tx_byte", 32'(b_tx_data), 32'(qb.pop_front()));
        end
    end

    task automatic cmd(input bit to_b, input logic [7:0] d);
        @(posedge clk); #1;
        if (to_b) begin b_rx_data = d; b_rx_done = 1; end
        else begin a_rx_data = d; a_rx_done = 1; end
        @(posedge clk); #1;
        a_rx_done = 0;
        b_rx_done = 0;
    endtask

    task automatic pulse_fin(input bit to_b);
        @(posedge clk); #1;
        if (to_b) b_fin = 1; else a_fin = 1;
        @(posedge clk); #1;
        a_fin = 0;
        b_fin = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input bit to_b, input int budget);
        int n = 0;
        while ((to_b ? b_busy : a_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(to_b ? b_busy : a_busy), 0);
    endtask

    task automatic push_a(input int words);
        for (int i = 0; i < words; i++) begin
            qa.push_back(a_mem[i][15:8]);
            qa.push_back(a_mem[i][7:0]);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1 << AW); i++) a_mem[i] = (i == 0) ? 16'h1234 : {8'(8'hA0 + i), 8'(8'h50 + i)};
        for (int i = 0; i < (1 << BA); i++) b_mem[i] = 8'(8'hC0 + i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_data", 32'(a_tx_data), 0);
        chk("rst_tx_start", 32'(a_tx_start), 0);
        chk("rst_sample", 32'(a_sample_start), 0);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_busy", 32'(a_busy), 0);
        rst_n = 1;
        cmd(0, 8'h41);
        cycles(3);
        chk("a_unknown_idle", 32'(a_busy), 0);
        cmd(0, 8'h53);
        cycles(3);
        chk("a_sample_pulse", 32'(a_samples), 1);
        chk("a_wait_sample_busy", 32'(a_busy), 1);
        push_a(1 << AW);
        pulse_fin(0);
        wait_idle("a_auto_done", 0, 3000);
        chk("a_auto_left", 32'(qa.size()), 0);
        chk("a_auto_addr", 32'(a_addr), 0);
        chk("a_sample_once", 32'(a_samples), 1);
        a_tbyte = 10;
        a_tlast = 10;
        push_a(1 << AW);
        cmd(0, 8'h44);
        wait_idle("a_dump_done", 0, 3000);
        chk("a_dump_left", 32'(qa.size()), 0);
        a_tbyte = 3;
        a_tlast = 3;
        push_a(3);
        qa.push_back(a_mem[3][15:8]);
        cmd(0, 8'h44);
        n = 0;
        while (!(a_addr == 3 && a_tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("a_abort_reach", 32'(a_addr), 3);
        cmd(0, 8'h58);
        wait_idle("a_abort_done", 0, 200);
        chk("a_abort_left", 32'(qa.size()), 0);
        chk("a_abort_addr", 32'(a_addr), 0);
        cycles(10);
        a_tbyte = 2;
        a_tlast = 1000;
        push_a(1 << AW);
        cmd(0, 8'h44);
        wait_idle("a_long_done", 0, 5000);
        chk("a_long_left", 32'(qa.size()), 0);
        chk("a_long_addr", 32'(a_addr), 0);
        cycles(20);
        chk("a_no_wrap", 32'(a_busy), 0);
        a_tlast = 2;
        push_a(1 << AW);
        cmd(0, 8'h44);
        n = 0;
        while (!a_tx_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("a_mid_send", 32'(a_tx_start), 1);
        #1 rst_n = 0;
        #1;
        chk("a_arst_tx_start", 32'(a_tx_start), 0);
        chk("a_arst_tx_data", 32'(a_tx_data), 0);
        chk("a_arst_busy", 32'(a_busy), 0);
        chk("a_arst_addr", 32'(a_addr), 0);
        qa.delete();
        cycles(2);
        rst_n = 1;
        cycles(15);
        chk("a_post_rst_busy", 32'(a_busy), 0);
        cmd(1, 8'h53);
        cycles(3);
        chk("b_sample_pulse", 32'(b_samples), 1);
        pulse_fin(1);
        cycles(20);
        chk("b_no_auto", 32'(b_busy), 0);
        cmd(1, 8'h41);
        cycles(3);
        chk("b_unknown_idle", 32'(b_busy), 0);
        for (int i = 0; i < (1 << BA); i++) qb.push_back(b_mem[i]);
        cmd(1, 8'h44);
        wait_idle("b_dump_done", 1, 1000);
        chk("b_dump_left", 32'(qb.size()), 0);
        chk("b_dump_addr", 32'(b_addr), 0);
        cycles(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
